// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS multiply/divide unit: operand width,
// op encoding as seen on the op port, and the FSM state encoding.
package mips_pkg;

  localparam int WIDTH = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/mips_muldiv_if.sv
// Request/result bundle between the datapath (master) and the mul/div unit
// (slave).
//
// Handshake: the master raises start with op/a/b valid for one clock. The
// request is taken on that posedge only if busy=0; while busy=1 start is
// ignored and nothing is re-sampled. busy stays high for the whole operation.
// done is a one-cycle pulse and hi/lo carry the new result in that cycle.
// busy is already low during done, so a new start in the done cycle is
// accepted. we_hi/we_lo (mthi/mtlo) are honoured only while busy=0.
interface mips_muldiv_if #(
  parameter int WIDTH = mips_pkg::WIDTH
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             we_hi;
  logic             we_lo;
  logic [WIDTH-1:0] wd;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, we_hi, we_lo, wd,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, we_hi, we_lo, wd,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mips_muldiv_step.sv
// One iteration of the mul/div datapath, purely combinational.
// Multiply: add-shift. {i_hi,i_lo} holds partial product / remaining
//   multiplier bits; i_m is the multiplicand magnitude.
// Divide (only with MIPS_MULDIV_DIV_EN): restoring trial subtract.
//   i_hi is the partial remainder, i_lo shifts the dividend out and the
//   quotient in; i_m is the divisor magnitude.
module muldiv_step #(
  parameter int WIDTH = 32
) (
`ifdef MIPS_MULDIV_DIV_EN
  input  logic             i_div,
`endif
  input  logic [WIDTH-1:0] i_hi,
  input  logic [WIDTH-1:0] i_lo,
  input  logic [WIDTH-1:0] i_m,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  logic [WIDTH:0] w_sum;
  assign w_sum = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_m} : '0);

`ifdef MIPS_MULDIV_DIV_EN
  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_trial;
  assign w_shift = {i_hi, i_lo[WIDTH-1]};
  assign w_trial = w_shift - {1'b0, i_m};

  // Pick the multiply or divide iteration; trial MSB set means "restore".
  always_comb begin
    if (i_div) begin
      o_hi = w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
      o_lo = {i_lo[WIDTH-2:0], ~w_trial[WIDTH]};
    end else begin
      o_hi = w_sum[WIDTH:1];
      o_lo = {w_sum[0], i_lo[WIDTH-1:1]};
    end
  end
`else
  assign o_hi = w_sum[WIDTH:1];
  assign o_lo = {w_sum[0], i_lo[WIDTH-1:1]};
`endif

endmodule

// File: rtl/mips_muldiv.sv
// Iterative MIPS multiply/divide unit holding the architectural HI/LO.
// IDLE -> CALC (WIDTH iterations) -> FIX (sign fix, HI/LO write) -> IDLE.
// Optional feature macro: MIPS_MULDIV_DIV_EN builds the divide datapath;
// without it, div/divu keep the same timing but leave HI/LO unchanged.
module mips_muldiv
  import mips_pkg::*;
#(
  parameter int WIDTH = mips_pkg::WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  mips_muldiv_if.slave bus,
  output state_t       o_dbg_state
);

  localparam int CW = $clog2(WIDTH);

  state_t           r_state, w_next;
  logic             w_load, w_fix, w_busy;
  logic [CW-1:0]    r_cnt;
  logic [1:0]       r_op;
  logic             r_sa, r_sb;
  logic [WIDTH-1:0] r_m, r_acc_hi, r_acc_lo;
  logic [WIDTH-1:0] r_hi, r_lo;
  logic             r_done;
  logic [WIDTH-1:0] w_step_hi, w_step_lo;
  logic             w_sa, w_sb;
  logic [WIDTH-1:0] w_mag_a, w_mag_b;
  logic [2*WIDTH-1:0] w_prod;

  // Signs only matter for the signed ops (op[0]=0); magnitudes feed the core.
  assign w_sa    = bus.a[WIDTH-1] & ~bus.op[0];
  assign w_sb    = bus.b[WIDTH-1] & ~bus.op[0];
  assign w_mag_a = w_sa ? -bus.a : bus.a;
  assign w_mag_b = w_sb ? -bus.b : bus.b;

  assign w_prod = (r_op == OP_MULT && (r_sa ^ r_sb)) ? -{r_acc_hi, r_acc_lo}
                                                     : {r_acc_hi, r_acc_lo};

  muldiv_step #(.WIDTH(WIDTH)) u_step (
`ifdef MIPS_MULDIV_DIV_EN
    .i_div (r_op[1]),
`endif
    .i_hi  (r_acc_hi),
    .i_lo  (r_acc_lo),
    .i_m   (r_m),
    .o_hi  (w_step_hi),
    .o_lo  (w_step_lo)
  );

`ifdef MIPS_MULDIV_DIV_EN
  logic [WIDTH-1:0] r_a;
  logic             r_b_zero;
  logic [WIDTH-1:0] w_div_hi, w_div_lo;

  // Divide sign fix; divide by zero returns HI=a, LO=all ones.
  always_comb begin
    w_div_lo = (r_op == OP_DIV && (r_sa ^ r_sb)) ? -r_acc_lo : r_acc_lo;
    w_div_hi = (r_op == OP_DIV && r_sa) ? -r_acc_hi : r_acc_hi;
    if (r_b_zero) begin
      w_div_hi = r_a;
      w_div_lo = '1;
    end
  end
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // FSM next state and control strobes.
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_fix  = 1'b0;
    case (r_state)
      S_IDLE: if (bus.start) begin
        w_next = S_CALC;
        w_load = 1'b1;
      end
      S_CALC: if (r_cnt == '0) w_next = S_FIX;
      S_FIX: begin
        w_next = S_IDLE;
        w_fix  = 1'b1;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_busy = (r_state != S_IDLE);

  // Operand latch, iteration, HI/LO write-back and mthi/mtlo.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_op     <= '0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_m      <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
`ifdef MIPS_MULDIV_DIV_EN
      r_a      <= '0;
      r_b_zero <= 1'b0;
`endif
    end else begin
      r_done <= w_fix;
      if (!w_busy && bus.we_hi) r_hi <= bus.wd;
      if (!w_busy && bus.we_lo) r_lo <= bus.wd;
      if (w_load) begin
        r_cnt    <= CW'(WIDTH - 1);
        r_op     <= bus.op;
        r_sa     <= w_sa;
        r_sb     <= w_sb;
        r_acc_hi <= '0;
`ifdef MIPS_MULDIV_DIV_EN
        r_a      <= bus.a;
        r_b_zero <= (bus.b == '0);
        if (bus.op[1]) begin
          r_acc_lo <= w_mag_a;
          r_m      <= w_mag_b;
        end else
`endif
        begin
          r_acc_lo <= w_mag_b;
          r_m      <= w_mag_a;
        end
      end else if (r_state == S_CALC) begin
        r_acc_hi <= w_step_hi;
        r_acc_lo <= w_step_lo;
        if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      end
      if (w_fix) begin
        if (!r_op[1]) begin
          r_hi <= w_prod[2*WIDTH-1:WIDTH];
          r_lo <= w_prod[WIDTH-1:0];
        end
`ifdef MIPS_MULDIV_DIV_EN
        else begin
          r_hi <= w_div_hi;
          r_lo <= w_div_lo;
        end
`endif
      end
    end
  end

  assign bus.busy    = w_busy;
  assign bus.done    = r_done;
  assign bus.hi      = r_hi;
  assign bus.lo      = r_lo;
  assign o_dbg_state = r_state;

endmodule
